// File: rtl/aes_stream_host_pkg.sv
// Shared types and constants for the AES core word-stream host endpoint.
package aes_stream_host_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned TYPE_W          = 2;
  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned CNT_W           = 2;
  localparam int unsigned IDX_W           = 3;
  localparam int unsigned GAP_W           = 3;

  localparam logic [TYPE_W-1:0] TYPE_KEY  = 2'b01;
  localparam logic [TYPE_W-1:0] TYPE_DATA = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [TYPE_W-1:0]  typ;
    logic [BLOCK_W-1:0] data;
  } host_req_t;

  // Word idx of a block, most-significant word first.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [CNT_W-1:0]   idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_word_collector.sv
// Gathers four core output words into a 128-bit response held until the host takes it.
module aes_word_collector
  import aes_stream_host_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic               i_type,
  input  logic [WORD_W-1:0]  i_data,
  input  logic               i_rsp_ready,
  output logic               o_rsp_valid,
  output logic               o_rsp_type,
  output logic [BLOCK_W-1:0] o_rsp_data,
  output logic               o_overflow
);

  localparam int unsigned BUF_W = (WORDS_PER_BLOCK - 1) * WORD_W;

  logic [CNT_W-1:0]   r_cnt;
  logic [BUF_W-1:0]   r_buf;
  logic               r_first_type;
  logic               r_rsp_valid;
  logic               r_rsp_type;
  logic [BLOCK_W-1:0] r_rsp_data;
  logic               r_overflow;

  logic               w_last;
  logic               w_rsp_free;
  logic [BLOCK_W-1:0] w_block;

  assign w_last     = i_valid && (r_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
  assign w_rsp_free = !r_rsp_valid || i_rsp_ready;
  assign w_block    = {r_buf, i_data};

  // A block completing while the response is still owed to the host is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_buf        <= '0;
      r_first_type <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_type   <= 1'b0;
      r_rsp_data   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (r_rsp_valid && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      if (i_valid) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == '0) begin
          r_first_type <= i_type;
        end
        if (w_last) begin
          if (w_rsp_free) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_block;
            r_rsp_type  <= r_first_type;
          end else begin
            r_overflow <= 1'b1;
          end
        end else begin
          r_buf <= {r_buf[BUF_W-WORD_W-1:0], i_data};
        end
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_type  = r_rsp_type;
  assign o_rsp_data  = r_rsp_data;
  assign o_overflow  = r_overflow;

endmodule

// File: rtl/aes_stream_host.sv
// Host endpoint for the AES core: serialises 128-bit requests into typed words
// and collects core output words into 128-bit responses.
module aes_stream_host
  import aes_stream_host_pkg::*;
#(
  parameter int unsigned WORD_GAP = 0
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TYPE_W-1:0]  req_type,
  input  logic [BLOCK_W-1:0] req_data,
  output logic               data_in_valid,
  output logic [TYPE_W-1:0]  data_in_type,
  output logic [WORD_W-1:0]  data_in,
  input  logic               crypto_ready,
  input  logic               data_out_valid,
  input  logic               data_out_type,
  input  logic [WORD_W-1:0]  data_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_type,
  output logic [BLOCK_W-1:0] rsp_data,
  output logic               overflow,
  output logic               bad_type
);

  tx_state_e         r_state;
  host_req_t         r_req;
  logic              r_req_ready;
  logic              r_dv;
  logic [WORD_W-1:0] r_word;
  logic [IDX_W-1:0]  r_idx;
  logic [GAP_W-1:0]  r_gap;
  logic              r_bad;

  logic              w_req_fire;

  assign w_req_fire = req_valid && r_req_ready;

  // Word 0 is emitted on the edge that enters SEND so the first word follows
  // the handshake (key) or crypto_ready (data) by exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_req_ready <= 1'b0;
      r_dv        <= 1'b0;
      r_word      <= '0;
      r_idx       <= '0;
      r_gap       <= '0;
      r_bad       <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_req_fire) begin
            r_req <= '{typ: req_type, data: req_data};
            if (req_type == TYPE_KEY) begin
              r_state     <= SEND;
              r_req_ready <= 1'b0;
              r_dv        <= 1'b1;
              r_word      <= block_word(req_data, CNT_W'(0));
              r_idx       <= IDX_W'(1);
              r_gap       <= GAP_W'(WORD_GAP);
            end else if (req_type == TYPE_DATA) begin
              r_state     <= WAIT;
              r_req_ready <= 1'b0;
            end else begin
              r_bad <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (crypto_ready) begin
            r_state <= SEND;
            r_dv    <= 1'b1;
            r_word  <= block_word(r_req.data, CNT_W'(0));
            r_idx   <= IDX_W'(1);
            r_gap   <= GAP_W'(WORD_GAP);
          end
        end
        SEND: begin
          if (r_idx == IDX_W'(WORDS_PER_BLOCK)) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
          end else if (r_gap == '0) begin
            r_dv   <= 1'b1;
            r_word <= block_word(r_req.data, r_idx[CNT_W-1:0]);
            r_idx  <= r_idx + IDX_W'(1);
            r_gap  <= GAP_W'(WORD_GAP);
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign data_in_valid = r_dv;
  assign data_in_type  = r_req.typ;
  assign data_in       = r_word;
  assign bad_type      = r_bad;

  aes_word_collector u_collector (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (data_out_valid),
    .i_type      (data_out_type),
    .i_data      (data_out),
    .i_rsp_ready (rsp_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_type  (rsp_type),
    .o_rsp_data  (rsp_data),
    .o_overflow  (overflow)
  );

endmodule

// File: tb/tb_aes_stream_host.sv
// Bench for aes_stream_host: directed host/core traffic, a block-level model and literal pins.
module tb_aes_stream_host;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_type = 2'b00;
  logic [127:0] req_data = '0;
  logic         data_in_valid;
  logic [1:0]   data_in_type;
  logic [31:0]  data_in;
  logic         crypto_ready = 1'b0;
  logic         data_out_valid = 1'b0;
  logic         data_out_type = 1'b0;
  logic [31:0]  data_out = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_type;
  logic [127:0] rsp_data;
  logic         overflow;
  logic         bad_type;

  aes_stream_host dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_type       (req_type),
    .req_data       (req_data),
    .data_in_valid  (data_in_valid),
    .data_in_type   (data_in_type),
    .data_in        (data_in),
    .crypto_ready   (crypto_ready),
    .data_out_valid (data_out_valid),
    .data_out_type  (data_out_type),
    .data_out       (data_out),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_type       (rsp_type),
    .rsp_data       (rsp_data),
    .overflow       (overflow),
    .bad_type       (bad_type)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endfunction

  // Expected transmit words, appended by the request task.
  typedef struct {
    logic [1:0]  typ;
    logic [31:0] data;
  } txw_t;
  txw_t tx_exp[$];
  int   tx_skip = 0;
  int   tx_rd   = 0;
  logic m_bad   = 1'b0;

  // Response model: place each word by its position, hand over whole blocks.
  logic         m_rsp_valid = 1'b0;
  logic         m_rsp_type  = 1'b0;
  logic [127:0] m_rsp_data  = '0;
  logic         m_ovf       = 1'b0;
  logic [127:0] m_blk       = '0;
  logic         m_first     = 1'b0;
  int           m_cnt       = 0;

  always @(posedge clk) begin : rx_model
    logic [127:0] blk;
    int           cnt;
    logic         busy;
    if (rst) begin
      m_rsp_valid <= 1'b0;
      m_rsp_type  <= 1'b0;
      m_rsp_data  <= '0;
      m_ovf       <= 1'b0;
      m_blk       <= '0;
      m_first     <= 1'b0;
      m_cnt       <= 0;
    end else begin
      blk  = m_blk;
      cnt  = m_cnt;
      busy = m_rsp_valid && !rsp_ready;
      if (data_out_valid) begin
        blk[32*(3-cnt) +: 32] = data_out;
        if (cnt == 0) m_first <= data_out_type;
        if (cnt == 3) begin
          if (busy) m_ovf <= 1'b1;
          else begin
            m_rsp_data <= blk;
            m_rsp_type <= m_first;
            busy = 1'b1;
          end
          cnt = 0;
        end else begin
          cnt = cnt + 1;
        end
      end
      m_rsp_valid <= busy;
      m_blk       <= blk;
      m_cnt       <= cnt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (tx_rd < tx_skip) tx_rd = tx_skip;
      if (data_in_valid !== 1'b0) begin
        if (tx_rd >= tx_exp.size()) begin
          chk("tx_unexpected_word", 128'(data_in_valid), 128'(1'b0));
        end else begin
          chk("tx_word", 128'(data_in), 128'(tx_exp[tx_rd].data));
          chk("tx_type", 128'(data_in_type), 128'(tx_exp[tx_rd].typ));
          tx_rd++;
        end
      end
      chk("rsp_valid", 128'(rsp_valid), 128'(m_rsp_valid));
      if (m_rsp_valid) begin
        chk("rsp_data", rsp_data, m_rsp_data);
        chk("rsp_type", 128'(rsp_type), 128'(m_rsp_type));
      end
      chk("overflow", 128'(overflow), 128'(m_ovf));
      chk("bad_type", 128'(bad_type), 128'(m_bad));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_req(input logic [1:0] t, input logic [127:0] d);
    int budget;
    budget    = 0;
    req_valid = 1'b1;
    req_type  = t;
    req_data  = d;
    @(negedge clk);
    while (req_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (req_ready !== 1'b1) chk("req_ready_timeout", 128'(req_ready), 128'(1'b1));
    tick();
    req_valid = 1'b0;
    if (t == 2'b01 || t == 2'b10) begin
      for (int i = 0; i < 4; i++) tx_exp.push_back('{t, d[32*(3-i) +: 32]});
    end else begin
      m_bad = 1'b1;
    end
  endtask

  task automatic core_word(input logic t, input logic [31:0] w, input logic rdy);
    data_out_valid = 1'b1;
    data_out_type  = t;
    data_out       = w;
    rsp_ready      = rdy;
    tick();
    data_out_valid = 1'b0;
    rsp_ready      = 1'b0;
  endtask

  task automatic core_block(input logic t, input logic [127:0] b, input int gap, input logic rdy_last);
    for (int i = 0; i < 4; i++) begin
      core_word((i == 0) ? t : ~t, b[32*(3-i) +: 32], (i == 3) ? rdy_last : 1'b0);
      if (i < 3) repeat (gap) tick();
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  localparam logic [127:0] KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] PT  = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] B1  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] B2  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] B3  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] B4  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] B5  = 128'hffeeddcc_bbaa9988_77665544_33221100;
  localparam logic [127:0] PT2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  initial begin
    logic [31:0] key_w [4];
    logic [31:0] pt_w  [4];
    key_w = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
    pt_w  = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};

    // Reset values
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(1'b0));
    chk("rst_data_in_valid", 128'(data_in_valid), 128'(1'b0));
    chk("rst_data_in", 128'(data_in), 128'(32'h0));
    chk("rst_data_in_type", 128'(data_in_type), 128'(2'b00));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("rst_rsp_data", rsp_data, 128'h0);
    chk("rst_rsp_type", 128'(rsp_type), 128'(1'b0));
    chk("rst_overflow", 128'(overflow), 128'(1'b0));
    chk("rst_bad_type", 128'(bad_type), 128'(1'b0));
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_req_ready", 128'(req_ready), 128'(1'b1));
    tick();

    // Key request: four consecutive words, req_ready low for four cycles
    host_req(2'b01, KEY);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("key_valid", 128'(data_in_valid), 128'(1'b1));
      chk("key_word", 128'(data_in), 128'(key_w[k]));
      chk("key_type", 128'(data_in_type), 128'(2'b01));
      chk("key_busy_ready", 128'(req_ready), 128'(1'b0));
    end
    @(negedge clk);
    chk("key_ready_back", 128'(req_ready), 128'(1'b1));
    chk("key_no_fifth", 128'(data_in_valid), 128'(1'b0));
    tick();

    // Data request stalled on crypto_ready, then crypto_ready dropped mid-send
    host_req(2'b10, PT);
    repeat (10) begin
      @(negedge clk);
      chk("data_wait_quiet", 128'(data_in_valid), 128'(1'b0));
    end
    tick();
    crypto_ready = 1'b1;
    @(negedge clk);
    chk("data_first_latency", 128'(data_in_valid), 128'(1'b0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("data_valid", 128'(data_in_valid), 128'(1'b1));
      chk("data_word", 128'(data_in), 128'(pt_w[k]));
      chk("data_type", 128'(data_in_type), 128'(2'b10));
      crypto_ready = 1'b0;
    end
    @(negedge clk);
    chk("data_ready_back", 128'(req_ready), 128'(1'b1));
    tick();

    // Response collection with gaps, held until consumed
    core_block(1'b1, B1, 2, 1'b0);
    @(negedge clk);
    chk("rx_valid", 128'(rsp_valid), 128'(1'b1));
    chk("rx_data", rsp_data, B1);
    chk("rx_type", 128'(rsp_type), 128'(1'b1));
    repeat (3) begin
      @(negedge clk);
      chk("rx_hold", rsp_data, B1);
    end
    tick();

    // Second block while first is pending: dropped
    core_block(1'b1, B2, 1, 1'b0);
    @(negedge clk);
    chk("ovf_set", 128'(overflow), 128'(1'b1));
    chk("ovf_keep_data", rsp_data, B1);
    chk("ovf_keep_valid", 128'(rsp_valid), 128'(1'b1));
    tick();
    consume();
    @(negedge clk);
    chk("consumed", 128'(rsp_valid), 128'(1'b0));
    tick();
    core_block(1'b1, B3, 0, 1'b0);
    @(negedge clk);
    chk("third_accepted", rsp_data, B3);
    chk("ovf_sticky", 128'(overflow), 128'(1'b1));
    tick();

    // Word 3 arriving with rsp_ready: no bubble
    core_block(1'b0, B4, 0, 1'b1);
    @(negedge clk);
    chk("swap_valid", 128'(rsp_valid), 128'(1'b1));
    chk("swap_data", rsp_data, B4);
    chk("swap_type", 128'(rsp_type), 128'(1'b0));
    tick();
    consume();

    // Reserved request type
    host_req(2'b11, PT);
    repeat (3) begin
      @(negedge clk);
      chk("rsv_ready", 128'(req_ready), 128'(1'b1));
      chk("rsv_no_word", 128'(data_in_valid), 128'(1'b0));
      chk("rsv_bad", 128'(bad_type), 128'(1'b1));
    end
    tick();

    // Reset in the middle of a data request and a partial response block
    crypto_ready = 1'b1;
    core_word(1'b1, 32'hcafe0001, 1'b0);
    core_word(1'b0, 32'hcafe0002, 1'b0);
    host_req(2'b10, PT2);
    tick();
    tick();
    @(negedge clk);
    chk("mid_word1", 128'(data_in), 128'(32'h04050607));
    rst = 1'b1;
    tick();
    tx_skip = tx_exp.size();
    m_bad   = 1'b0;
    @(negedge clk);
    chk("mrst_data_in_valid", 128'(data_in_valid), 128'(1'b0));
    chk("mrst_data_in", 128'(data_in), 128'(32'h0));
    chk("mrst_data_in_type", 128'(data_in_type), 128'(2'b00));
    chk("mrst_req_ready", 128'(req_ready), 128'(1'b0));
    chk("mrst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("mrst_rsp_data", rsp_data, 128'h0);
    chk("mrst_overflow", 128'(overflow), 128'(1'b0));
    chk("mrst_bad_type", 128'(bad_type), 128'(1'b0));
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("mrst_tx_quiet", 128'(data_in_valid), 128'(1'b0));
    end
    tick();
    core_block(1'b1, B5, 0, 1'b0);
    @(negedge clk);
    chk("mrst_rx_fresh", rsp_data, B5);
    chk("mrst_rx_type", 128'(rsp_type), 128'(1'b1));
    tick();
    consume();
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
